// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 shift-add) / restoring divide for the execute stage.
// Optional macro MULTDIV_OVF_EN adds multiply-overflow and INT_MIN/-1 exception reporting.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [2:0]       o_dbg_state
);

  // Handshake: a start (ctrl_MULT/ctrl_DIV) is taken on any rising edge where the
  // unit is IDLE or DONE; the result is valid for exactly the one cycle
  // data_resultRDY is high and then holds until the next accepted start.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]      r_step;
  logic               r_is_div;
  logic               r_sign;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;

  logic               w_accept;
  logic               w_start_mul;
  logic               w_start_div;
  logic               w_b_zero;
  logic               w_last_step;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_shift_rem;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_mag_lo;
  logic [WIDTH-1:0]   w_fix_result;
  logic               w_fix_exc;

  assign w_accept    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_mul = w_accept && ctrl_MULT;
  assign w_start_div = w_accept && ctrl_DIV && !ctrl_MULT;
  assign w_b_zero    = (data_operandB == '0);
  assign w_last_step = (r_step == CW'(WIDTH - 1));

  // Magnitudes are kept unsigned, so |INT_MIN| = 2^(WIDTH-1) is representable.
  assign w_a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // The remainder stays below the divisor, so one extra bit suffices for the trial.
  assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_dvsr};

  assign w_mag_lo     = r_is_div ? r_quo : r_acc[WIDTH-1:0];
  assign w_fix_result = r_sign ? -w_mag_lo : w_mag_lo;

`ifdef MULTDIV_OVF_EN
  logic               r_div_ovf;
  logic [2*WIDTH-1:0] w_signed_prod;
  logic [WIDTH:0]     w_prod_hi;
  logic               w_sign_eff;
  logic               w_mul_ovf;

  // A zero product is non-negative regardless of operand signs.
  assign w_signed_prod = r_sign ? -r_acc : r_acc;
  assign w_sign_eff    = r_sign && (r_acc != '0);
  assign w_prod_hi     = w_signed_prod[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf     = w_sign_eff ? !(&w_prod_hi) : (|w_prod_hi);
  assign w_fix_exc     = r_is_div ? r_div_ovf : w_mul_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_ovf <= 1'b0;
    end else if (w_start_div) begin
      r_div_ovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    end
  end
`else
  assign w_fix_exc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_start_div) begin
          w_state_nxt = w_b_zero ? S_DONE : S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last_step) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step   <= '0;
      r_is_div <= 1'b0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start_mul) begin
        r_is_div <= 1'b0;
        r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_step   <= '0;
      end else if (w_start_div) begin
        r_step <= '0;
        if (w_b_zero) begin
          r_result <= '0;
          r_exc    <= 1'b1;
          r_rdy    <= 1'b1;
        end else begin
          r_is_div <= 1'b1;
          r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          r_rem    <= '0;
          r_quo    <= w_a_mag;
          r_dvsr   <= w_b_mag;
        end
      end else begin
        case (r_state)
          S_MUL: begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_step   <= r_step + CW'(1);
          end
          S_DIV: begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift_rem[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_step <= r_step + CW'(1);
          end
          S_FIX: begin
            r_result <= w_fix_result;
            r_exc    <= w_fix_exc;
            r_rdy    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed table-driven bench for multdiv_seq plus hand-written multi-cycle sequences.
module tb_multdiv_seq;

`ifdef MULTDIV_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [2:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  multdiv_seq dut (
    .clk            (clk),
    .rst            (rst),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          mul;
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge. lat counts edges after the start edge until ready is seen
  // (0 means ready in the cycle right after the start edge).
  task automatic run_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, output logic [31:0] res, output logic exc,
                        output int lat, output int busy_n);
    bit done;
    done          = 1'b0;
    lat           = 0;
    busy_n        = 0;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = (k == inj_at);
      if (k == inj_at) data_operandB = '0;
      if (busy) busy_n++;
      if (data_resultRDY) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!done) lat = -1;
    res = data_result;
    exc = data_exception;
  endtask

  task automatic check_hold(input logic [31:0] exp_res, input logic exp_exc);
    @(posedge clk);
    @(negedge clk);
    check("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    check("hold_result", data_result, exp_res);
    check("hold_exc", {31'd0, data_exception}, {31'd0, exp_exc});
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          busy_n;
    bit          rdy_seen;

    vecs[0]  = '{1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0,   33, 33};
    vecs[1]  = '{0, 1, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 0,   33, 33};
    vecs[2]  = '{0, 1, 32'd100,        32'd7,         32'd14,        0,   33, 33};
    vecs[3]  = '{0, 1, 32'd5,          32'd0,         32'd0,         1,    0,  0};
    vecs[4]  = '{1, 0, 32'h0001_0000,  32'h0001_0000, 32'd0,         OVF, 33, 33};
    vecs[5]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, OVF, 33, 33};
    vecs[6]  = '{1, 0, 32'hFFFF_FFFA,  32'hFFFF_FFF9, 32'd42,        0,   33, 33};
    vecs[7]  = '{0, 1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0,   33, 33};
    vecs[8]  = '{1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0,   33, 33};
    vecs[9]  = '{1, 0, 32'd0,          32'hFFFF_FFFB, 32'd0,         0,   33, 33};
    vecs[10] = '{0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0,   33, 33};
    vecs[11] = '{1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, OVF, 33, 33};

    // reset
    rst           = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clk);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, o_dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(vecs[i].res);
      run_op(vecs[i].mul, vecs[i].div, vecs[i].a, vecs[i].b, -1, res, exc, lat, busy_n);
      check($sformatf("v%0d_result", i), res, exp_q.pop_front());
      check($sformatf("v%0d_exc", i), {31'd0, exc}, {31'd0, vecs[i].exc});
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].busy_n));
      check_hold(vecs[i].res, vecs[i].exc);
    end

    // divide (with zero divisor) pulsed mid-multiply is ignored
    run_op(1, 0, 32'd9, 32'd11, 5, res, exc, lat, busy_n);
    check("busy_div_ignored_result", res, 32'd99);
    check("busy_div_ignored_latency", 32'(lat), 32'd33);
    check("busy_div_ignored_exc", {31'd0, exc}, 32'd0);

    // back-to-back: second start issued in the ready cycle
    run_op(1, 0, 32'd6, 32'd7, -1, res, exc, lat, busy_n);
    check("b2b_first_result", res, 32'd42);
    run_op(1, 0, 32'hFFFF_FFFC, 32'd5, -1, res, exc, lat, busy_n);
    check("b2b_second_result", res, 32'hFFFF_FFEC);
    check("b2b_second_latency", 32'(lat), 32'd33);
    check("b2b_second_busy", 32'(busy_n), 32'd33);
    check_hold(32'hFFFF_FFEC, 1'b0);

    // simultaneous starts: multiply wins
    run_op(1, 1, 32'd6, 32'd7, -1, res, exc, lat, busy_n);
    check("both_start_result", res, 32'd42);
    check("both_start_latency", 32'(lat), 32'd33);
    check_hold(32'd42, 1'b0);

    // reset in the middle of a multiply
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd1000;
    @(posedge clk);
    @(negedge clk);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", {31'd0, data_exception}, 32'd0);
    check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    rdy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (data_resultRDY || busy) rdy_seen = 1'b1;
    end
    check("midrst_no_strobe", {31'd0, rdy_seen}, 32'd0);
    run_op(1, 0, 32'd3, 32'd4, -1, res, exc, lat, busy_n);
    check("post_rst_result", res, 32'd12);
    check("post_rst_latency", 32'(lat), 32'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
